// File: rtl/eth_mdio_engine_pkg.sv
// Shared definitions for the MDIO management-frame engine.
// Holds frame constants, the FSM state encoding, the per-state bit-counter
// load values and a helper that assembles the 32-bit post-preamble frame.
package eth_mdio_engine_pkg;

    localparam int         PRE_LEN  = 32;
    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Counter load values: (bits in state) - 1
    localparam logic [5:0] CNT_PRE  = 6'(PRE_LEN - 1);
    localparam logic [5:0] CNT_HDR  = 6'd13;
    localparam logic [5:0] CNT_TA   = 6'd1;
    localparam logic [5:0] CNT_DATA = 6'd15;

    // ST_ARM: request latched, waiting for the first MdcEn_n to drive bit 0.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_PRE  = 3'd2,
        ST_HDR  = 3'd3,
        ST_TA   = 3'd4,
        ST_DATA = 3'd5
    } state_t;

    // ST, OP, PHYAD, REGAD, TA, DATA. For reads the TA/DATA bits are never
    // driven onto the pad, so their contents here do not matter.
    function automatic logic [31:0] build_frame(input logic        write_op,
                                                input logic [4:0]  phy_addr,
                                                input logic [4:0]  reg_addr,
                                                input logic [15:0] wr_data);
        return {ST_CODE, (write_op ? OP_WRITE : OP_READ), phy_addr, reg_addr,
                2'b10, (write_op ? wr_data : 16'h0000)};
    endfunction

endpackage

// File: rtl/eth_mdio_shifter.sv
// Transmit / receive shift registers for the MDIO engine.
// Ports:
//   clk        host clock
//   load       parallel-load the transmit frame and clear the receive register
//   load_data  32-bit frame (ST through DATA, MSB first)
//   tx_shift   advance the transmit register by one bit (issued on MdcEn_n)
//   tx_msb     bit currently at the head of the transmit register
//   rx_shift   shift rx_bit into the receive register (issued on MdcEn)
//   rx_bit     sampled Mdi value
//   rx_data    receive register contents
module eth_mdio_shifter
    import eth_mdio_engine_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        tx_shift,
    output logic        tx_msb,
    input  logic        rx_shift,
    input  logic        rx_bit,
    output logic [15:0] rx_data
);

    logic [31:0] tx_sreg;
    logic [15:0] rx_sreg;

    // Pure datapath: no reset, every frame starts with a parallel load.
    always_ff @(posedge clk) begin
        if (load) begin
            tx_sreg <= load_data;
        end else if (tx_shift) begin
            tx_sreg <= {tx_sreg[30:0], 1'b0};
        end

        if (load) begin
            rx_sreg <= 16'h0000;
        end else if (rx_shift) begin
            rx_sreg <= {rx_sreg[14:0], rx_bit};
        end
    end

    assign tx_msb  = tx_sreg[31];
    assign rx_data = rx_sreg;

endmodule

// File: rtl/eth_mdio_engine.sv
// MDIO (IEEE 802.3 clause 22) management-frame engine.
// Runs one read or write frame per accepted Start, stepping one bit per
// MdcEn_n strobe and sampling read data on MdcEn strobes.
// Ports:
//   Clk, Reset_n        host clock, asynchronous active-low reset
//   MdcEn, MdcEn_n      strobes preceding MDC rise / fall
//   Start, WriteOp, NoPre, PhyAddr, RegAddr, WrData   request (latched on accept)
//   Mdi                 pad input
//   Mdo, MdoEn          pad output data / output enable
//   Busy, Done          frame in progress / one-cycle completion pulse
//   RdData              data from the last completed read
module eth_mdio_engine
    import eth_mdio_engine_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        MdcEn,
    input  logic        MdcEn_n,
    input  logic        Start,
    input  logic        WriteOp,
    input  logic        NoPre,
    input  logic [4:0]  PhyAddr,
    input  logic [4:0]  RegAddr,
    input  logic [15:0] WrData,
    input  logic        Mdi,
    output logic        Mdo,
    output logic        MdoEn,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] RdData
);

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        write_q, write_nxt;
    logic        nopre_q, nopre_nxt;
    logic        mdo_nxt, mdo_en_nxt, done_nxt;
    logic [15:0] rd_data_nxt;

    logic        load, tx_shift, rx_shift, tx_msb;
    logic [31:0] frame_word;
    logic [15:0] rx_data;
    logic        emit, drive;

    assign frame_word = build_frame(WriteOp, PhyAddr, RegAddr, WrData);

    eth_mdio_shifter u_shifter (
        .clk       (Clk),
        .load      (load),
        .load_data (frame_word),
        .tx_shift  (tx_shift),
        .tx_msb    (tx_msb),
        .rx_shift  (rx_shift),
        .rx_bit    (Mdi),
        .rx_data   (rx_data)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            cnt     <= 6'd0;
            write_q <= 1'b0;
            nopre_q <= 1'b0;
            Mdo     <= 1'b0;
            MdoEn   <= 1'b0;
            Done    <= 1'b0;
            RdData  <= 16'h0000;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            write_q <= write_nxt;
            nopre_q <= nopre_nxt;
            Mdo     <= mdo_nxt;
            MdoEn   <= mdo_en_nxt;
            Done    <= done_nxt;
            RdData  <= rd_data_nxt;
        end
    end

    assign Busy = (state != ST_IDLE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        write_nxt   = write_q;
        nopre_nxt   = nopre_q;
        mdo_nxt     = Mdo;
        mdo_en_nxt  = MdoEn;
        done_nxt    = 1'b0;
        rd_data_nxt = RdData;
        load        = 1'b0;
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;
        // emit: put the next transmit-register bit on the pad this strobe;
        // drive: whether that bit is actually driven (reads release TA/DATA).
        emit        = 1'b0;
        drive       = 1'b0;

        case (state)
            ST_IDLE: begin
                mdo_nxt    = 1'b0;
                mdo_en_nxt = 1'b0;
                if (Start) begin
                    load      = 1'b1;
                    write_nxt = WriteOp;
                    nopre_nxt = NoPre;
                    state_nxt = ST_ARM;
                end
            end

            ST_ARM: begin
                if (MdcEn_n) begin
                    if (nopre_q) begin
                        state_nxt = ST_HDR;
                        cnt_nxt   = CNT_HDR;
                        emit      = 1'b1;
                        drive     = 1'b1;
                    end else begin
                        state_nxt  = ST_PRE;
                        cnt_nxt    = CNT_PRE;
                        mdo_nxt    = 1'b1;
                        mdo_en_nxt = 1'b1;
                    end
                end
            end

            // Preamble ones are generated here, not stored in the shifter.
            ST_PRE: begin
                if (MdcEn_n) begin
                    if (cnt == 6'd0) begin
                        state_nxt = ST_HDR;
                        cnt_nxt   = CNT_HDR;
                        emit      = 1'b1;
                        drive     = 1'b1;
                    end else begin
                        cnt_nxt    = cnt - 6'd1;
                        mdo_nxt    = 1'b1;
                        mdo_en_nxt = 1'b1;
                    end
                end
            end

            ST_HDR: begin
                if (MdcEn_n) begin
                    emit = 1'b1;
                    if (cnt == 6'd0) begin
                        state_nxt = ST_TA;
                        cnt_nxt   = CNT_TA;
                        drive     = write_q;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                        drive   = 1'b1;
                    end
                end
            end

            ST_TA: begin
                if (MdcEn_n) begin
                    emit  = 1'b1;
                    drive = write_q;
                    if (cnt == 6'd0) begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = CNT_DATA;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
            end

            // MdcEn_n wins over a coincident MdcEn: the bit advances and the
            // Mdi sample for that cycle is dropped.
            ST_DATA: begin
                if (MdcEn_n) begin
                    if (cnt == 6'd0) begin
                        state_nxt  = ST_IDLE;
                        mdo_nxt    = 1'b0;
                        mdo_en_nxt = 1'b0;
                        done_nxt   = 1'b1;
                        if (!write_q) begin
                            rd_data_nxt = rx_data;
                        end
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                        emit    = 1'b1;
                        drive   = write_q;
                    end
                end else if (MdcEn && !write_q) begin
                    rx_shift = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (emit) begin
            tx_shift   = 1'b1;
            mdo_nxt    = drive & tx_msb;
            mdo_en_nxt = drive;
        end
    end

endmodule

// File: tb/tb_eth_mdio_engine.sv
// Testbench for eth_mdio_engine: frame-level reference model plus directed
// scenarios (write with preamble, read without, ignored Start, back-to-back
// reads, strobe collision, mid-frame reset).
module tb_eth_mdio_engine;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        MdcEn = 1'b0;
    logic        MdcEn_n = 1'b0;
    logic        Start = 1'b0;
    logic        WriteOp = 1'b0;
    logic        NoPre = 1'b0;
    logic [4:0]  PhyAddr = 5'h00;
    logic [4:0]  RegAddr = 5'h00;
    logic [15:0] WrData = 16'h0000;
    logic        Mdi = 1'b1;
    logic        Mdo, MdoEn, Busy, Done;
    logic [15:0] RdData;

    int n_vec = 0;
    int n_err = 0;

    eth_mdio_engine dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .MdcEn   (MdcEn),
        .MdcEn_n (MdcEn_n),
        .Start   (Start),
        .WriteOp (WriteOp),
        .NoPre   (NoPre),
        .PhyAddr (PhyAddr),
        .RegAddr (RegAddr),
        .WrData  (WrData),
        .Mdi     (Mdi),
        .Mdo     (Mdo),
        .MdoEn   (MdoEn),
        .Busy    (Busy),
        .Done    (Done),
        .RdData  (RdData)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model: frame as a list of bits ----------------
    logic        m_bits [64];
    logic        m_ens  [64];
    int          m_len = 0;
    int          m_idx = 0;
    logic        m_busy = 1'b0, m_pending = 1'b0, m_read = 1'b0;
    logic        m_mdo = 1'b0, m_en = 1'b0, m_done = 1'b0;
    logic [15:0] m_rd = 16'h0000, m_rx = 16'h0000, m_phy = 16'h0000;
    logic [15:0] phy_next = 16'h0000;   // data the PHY returns on the next read

    task automatic push_bit(input logic b, input logic e);
        m_bits[6'(m_len)] = b;
        m_ens[6'(m_len)]  = e;
        m_len++;
    endtask

    task automatic build(input logic w, input logic np, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd);
        m_len = 0;
        if (!np) for (int i = 0; i < 32; i++) push_bit(1'b1, 1'b1);
        push_bit(1'b0, 1'b1);
        push_bit(1'b1, 1'b1);
        push_bit(~w, 1'b1);
        push_bit(w, 1'b1);
        for (int i = 4; i >= 0; i--) push_bit(pa[i], 1'b1);
        for (int i = 4; i >= 0; i--) push_bit(ra[i], 1'b1);
        if (w) begin
            push_bit(1'b1, 1'b1);
            push_bit(1'b0, 1'b1);
            for (int i = 15; i >= 0; i--) push_bit(wd[i], 1'b1);
        end else begin
            for (int i = 0; i < 18; i++) push_bit(1'b0, 1'b0);
        end
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_busy = 1'b0; m_pending = 1'b0; m_mdo = 1'b0; m_en = 1'b0;
            m_done = 1'b0; m_rd = 16'h0000; m_idx = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (Start) begin
                    build(WriteOp, NoPre, PhyAddr, RegAddr, WrData);
                    m_read = ~WriteOp;
                    m_phy = phy_next;
                    m_rx = 16'h0000;
                    m_busy = 1'b1;
                    m_pending = 1'b1;
                end
            end else if (MdcEn_n) begin
                if (m_pending) begin
                    m_pending = 1'b0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
                if (m_idx == m_len) begin
                    m_busy = 1'b0; m_done = 1'b1; m_mdo = 1'b0; m_en = 1'b0;
                    if (m_read) m_rd = m_rx;
                end else begin
                    m_mdo = m_bits[6'(m_idx)];
                    m_en  = m_ens[6'(m_idx)];
                end
            end else if (MdcEn && !m_pending && m_read && m_idx >= m_len - 16) begin
                m_rx = {m_rx[14:0], Mdi};
            end
        end
    end

    // ---------------- MDC strobes (period 4) and PHY Mdi driver ----------------
    int ph = 0;
    int collide_bit = -1;   // DATA bit whose closing MdcEn_n also gets MdcEn
    int collided = 0;

    always @(posedge Clk) begin
        logic [3:0] k;
        #1;
        ph = (ph + 1) % 4;
        MdcEn   = (ph == 1);
        MdcEn_n = (ph == 3);
        Mdi = 1'b1;
        if (m_busy && m_read && !m_pending) begin
            if (m_idx == m_len - 17) begin
                Mdi = 1'b0;
            end else if (m_idx >= m_len - 16) begin
                k = 4'(m_len - 1 - m_idx);
                Mdi = m_phy[k];
            end
        end
        if (collided == 0 && collide_bit >= 0 && m_busy && m_read && !m_pending &&
            m_idx == m_len - 16 + collide_bit && ph == 3) begin
            MdcEn = 1'b1;
            Mdi = ~Mdi;
            collided++;
        end
    end

    // ---------------- checking ----------------
    logic [63:0] cap_mdo, cap_en;
    int          cap_n, done_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_cap();
        cap_mdo = 64'h0; cap_en = 64'h0; cap_n = 0; done_cnt = 0;
    endtask

    task automatic compare_loop();
        logic strobe_q;
        strobe_q = 1'b0;
        forever begin
            @(negedge Clk);
            if (strobe_q && !Done) begin
                cap_mdo = {cap_mdo[62:0], Mdo};
                cap_en  = {cap_en[62:0], MdoEn};
                cap_n++;
            end
            if (Done) done_cnt++;
            strobe_q = MdcEn_n && Busy;
            chk("Mdo",    64'(Mdo),    64'(m_mdo));
            chk("MdoEn",  64'(MdoEn),  64'(m_en));
            chk("Busy",   64'(Busy),   64'(m_busy));
            chk("Done",   64'(Done),   64'(m_done));
            chk("RdData", 64'(RdData), 64'(m_rd));
        end
    endtask

    task automatic request(input logic w, input logic np, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd);
        @(posedge Clk); #1;
        WriteOp = w; NoPre = np; PhyAddr = pa; RegAddr = ra; WrData = wd; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    // Returns at #1 after the edge that raised Done.
    task automatic wait_done(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(posedge Clk); #1;
            if (Done) break;
        end
        chk(name, 64'(i < limit), 64'd1);
    endtask

    initial begin
        clear_cap();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_mdo",    64'(Mdo),    64'd0);
        chk("rst_mdoen",  64'(MdoEn),  64'd0);
        chk("rst_busy",   64'(Busy),   64'd0);
        chk("rst_done",   64'(Done),   64'd0);
        chk("rst_rddata", 64'(RdData), 64'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge Clk);

        // Write with preamble; a second Start while busy must be ignored.
        clear_cap();
        request(1'b1, 1'b0, 5'h01, 5'h00, 16'h1234);
        repeat (40) @(posedge Clk);
        #1;
        WriteOp = 1'b0; PhyAddr = 5'h1F; RegAddr = 5'h1F; WrData = 16'hFFFF; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        wait_done("w1_done_seen", 400);
        repeat (2) @(posedge Clk);
        #1;
        chk("w1_nbits", 64'(cap_n), 64'd64);
        chk("w1_bits",  cap_mdo, 64'hFFFF_FFFF_5082_1234);
        chk("w1_en",    cap_en,  64'hFFFF_FFFF_FFFF_FFFF);
        chk("w1_ndone", 64'(done_cnt), 64'd1);

        // Read without preamble, PHY returns BEEF.
        clear_cap();
        phy_next = 16'hBEEF;
        request(1'b0, 1'b1, 5'h1F, 5'h02, 16'h0000);
        wait_done("r1_done_seen", 200);
        chk("r1_rddata", 64'(RdData), 64'hBEEF);
        repeat (2) @(posedge Clk);
        #1;
        chk("r1_nbits", 64'(cap_n), 64'd32);
        chk("r1_bits",  cap_mdo, 64'h0000_0000_6F88_0000);
        chk("r1_en",    cap_en,  64'h0000_0000_FFFC_0000);
        chk("r1_ndone", 64'(done_cnt), 64'd1);

        // Back-to-back reads: second Start issued in the first Done cycle.
        phy_next = 16'h1357;
        request(1'b0, 1'b1, 5'h03, 5'h04, 16'h0000);
        wait_done("r2_done_seen", 200);
        chk("r2_rddata", 64'(RdData), 64'h1357);
        phy_next = 16'hA5C3;
        WriteOp = 1'b0; NoPre = 1'b1; PhyAddr = 5'h05; RegAddr = 5'h06; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("r3_accepted", 64'(Busy), 64'd1);
        repeat (50) @(posedge Clk);
        #1;
        chk("r3_hold_rddata", 64'(RdData), 64'h1357);
        wait_done("r3_done_seen", 200);
        chk("r3_rddata", 64'(RdData), 64'hA5C3);

        // Read with MdcEn and MdcEn_n together at the end of DATA bit 5.
        collide_bit = 5;
        phy_next = 16'h8E71;
        request(1'b0, 1'b1, 5'h0A, 5'h0B, 16'h0000);
        wait_done("r4_done_seen", 200);
        chk("r4_rddata", 64'(RdData), 64'h8E71);
        chk("r4_collided", 64'(collided), 64'd1);

        // Reset during DATA bit 8 of a write, then a fresh read.
        repeat (3) @(posedge Clk);
        clear_cap();
        request(1'b1, 1'b0, 5'h02, 5'h03, 16'hABCD);
        begin
            int i;
            for (i = 0; i < 400; i++) begin
                @(posedge Clk); #1;
                if (m_busy && !m_pending && m_idx == m_len - 16 + 8) break;
            end
            chk("w5_reached_bit8", 64'(i < 400), 64'd1);
        end
        Reset_n = 1'b0;
        #1;
        chk("w5_rst_mdo",    64'(Mdo),    64'd0);
        chk("w5_rst_mdoen",  64'(MdoEn),  64'd0);
        chk("w5_rst_busy",   64'(Busy),   64'd0);
        chk("w5_rst_rddata", 64'(RdData), 64'd0);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        chk("w5_no_done", 64'(done_cnt), 64'd0);
        phy_next = 16'h4B2D;
        request(1'b0, 1'b0, 5'h04, 5'h05, 16'h0000);
        wait_done("r6_done_seen", 400);
        chk("r6_rddata", 64'(RdData), 64'h4B2D);
        repeat (4) @(posedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eth_mdio_engine.md
ETH_MDIO_ENGINE -- requirements
Module: eth_mdio_engine

Interface
REQ-001 Clk  input  1  host clock; sole clock of the block.
REQ-002 Reset_n  input  1  asynchronous, active-low reset.
REQ-003 MdcEn  input  1  one-Clk strobe from the MDC clock generator, asserted the Clk cycle before Mdc rises.
REQ-004 MdcEn_n  input  1  one-Clk strobe from the MDC clock generator, asserted the Clk cycle before Mdc falls.
REQ-005 Start  input  1  single-cycle request to run one management frame.
REQ-006 WriteOp  input  1  1 = write frame, 0 = read frame; sampled with Start.
REQ-007 NoPre  input  1  1 = omit 32-bit preamble; sampled with Start.
REQ-008 PhyAddr  input  5  PHY address; sampled with Start.
REQ-009 RegAddr  input  5  register address; sampled with Start.
REQ-010 WrData  input  16  write data; sampled with Start.
REQ-011 Mdi  input  1  MDIO input from pad.
REQ-012 Mdo  output  1  MDIO output data to pad.
REQ-013 MdoEn  output  1  MDIO output enable (1 = block drives pad).
REQ-014 Busy  output  1  frame in progress.
REQ-015 Done  output  1  one-Clk pulse at frame completion.
REQ-016 RdData  output  16  data captured by the last completed read frame.

Function
REQ-017 Frame bit order SHALL be: preamble 32x'1' (unless NoPre), ST=01, OP (write 01, read 10), PhyAddr MSB first, RegAddr MSB first, TA (2 bits), data 16 bits MSB first; 64 bits total, 32 with NoPre.
REQ-018 Start SHALL be accepted only when Busy=0; all request inputs are latched in that cycle and Busy SHALL be 1 from the next Clk; Start while Busy=1 is ignored.
REQ-019 Bit boundaries SHALL occur only on MdcEn_n: the first frame bit is driven (Mdo updated, MdoEn=1) on the first MdcEn_n strictly after acceptance; each later bit advances on each following MdcEn_n.
REQ-020 Mdo and MdoEn SHALL change only in the Clk cycle following an MdcEn_n strobe, never on MdcEn.
REQ-021 State machine SHALL be IDLE -> PRE (32 bits) -> HDR (14 bits: ST,OP,PHYAD,REGAD) -> TA (2 bits) -> DATA (16 bits) -> IDLE; NoPre=1 goes IDLE -> HDR directly.
REQ-022 Write TA SHALL drive 1 then 0 with MdoEn=1; write DATA drives WrData with MdoEn=1.
REQ-023 Read TA and DATA SHALL hold MdoEn=0 for all 18 bit periods; Mdo=0 while released.
REQ-024 Read data SHALL be sampled from Mdi in the cycle MdcEn=1 during each of the 16 DATA bit periods, shifted MSB first into an internal register.
REQ-025 At the MdcEn_n ending the last DATA bit: MdoEn=0, Mdo=0, Done=1 for exactly one Clk, Busy=0 in the same cycle, state IDLE.
REQ-026 RdData SHALL update only in the Done cycle of a read frame; writes leave RdData unchanged.
REQ-027 A new Start is accepted in the Done cycle or later; back-to-back frames have no idle bit other than MdcEn_n alignment.
REQ-028 Bit counter SHALL be 6 bits, loaded per state (31,13,1,15) and decremented per MdcEn_n; state advances when count=0 and MdcEn_n=1.
REQ-029 If MdcEn and MdcEn_n are asserted in the same cycle, MdcEn_n actions SHALL take priority and the Mdi sample is dropped.
REQ-030 In IDLE: Mdo=0, MdoEn=0, Busy=0.

Reset
REQ-031 Reset_n=0 SHALL immediately force IDLE, Mdo=0, MdoEn=0, Busy=0, Done=0, RdData=16'h0000, bit counter 0.
REQ-032 Reset mid-frame SHALL abort with no Done pulse; first Start after release behaves as from power-up.

Structure
REQ-033 Shared defines file SHALL hold: preamble length 32, ST code 2'b01, OP_WRITE 2'b01, OP_READ 2'b10, state encodings, counter load values.
REQ-034 One sub-module eth_mdio_shifter SHALL hold the 32-bit transmit shift register (parallel load, shift on MdcEn_n) and 16-bit receive shift register (shift on MdcEn).

Verification
REQ-035 Write, NoPre=0, PhyAddr=5'h01, RegAddr=5'h00, WrData=16'h1234, Divider-style strobes every 4 Clk -> Mdo sequence 32x1, 01, 01, 00001, 00000, 10, 0001001000110100; MdoEn=1 throughout; one Done.
REQ-036 Read, NoPre=1, PhyAddr=5'h1F, RegAddr=5'h02, model drives 16'hBEEF on Mdi from TA bit 2 -> MdoEn drops after RegAddr LSB, RdData=16'hBEEF at Done, 32 bit periods total.
REQ-037 Start pulsed again while Busy=1 with different address -> ignored, frame bits unchanged, single Done.
REQ-038 Reset_n asserted during DATA bit 8 of a write -> Mdo=0, MdoEn=0, Busy=0 immediately, no Done; next read completes with correct RdData.
REQ-039 Start issued in Done cycle of a read -> accepted, second frame starts on next MdcEn_n, RdData holds first read value until second Done.
REQ-040 MdcEn and MdcEn_n forced together in one DATA cycle of a read -> bit advances, that Mdi sample is not taken.
